// File: rtl/flog_pkg.sv
// Shared widths, bias and FSM state type for the bfloat16 log2 datapath.
// The optional FX2BF16_RNE_EN build also uses W and the widths below.
package flog_pkg;
  localparam int EXP    = 8;
  localparam int MAN    = 7;
  localparam int FRAC_W = 7;
  localparam int BIAS   = 127;
  localparam int W      = EXP + FRAC_W;
  localparam int CNT_W  = $clog2(W);

  typedef enum logic [1:0] {IDLE, ABS, NORM, OUT} fx2bf_state_t;
endpackage

// File: rtl/bf16_round_rne.sv
// Round-to-nearest-even of a normalised magnitude (leading one at bit W-1).
// Only built when FX2BF16_RNE_EN is defined.
`ifdef FX2BF16_RNE_EN
module bf16_round_rne
  import flog_pkg::*;
(
  input  logic [W-1:0]   mag_i,
  input  logic [EXP-1:0] e_i,
  output logic [MAN-1:0] f_o,
  output logic [EXP-1:0] e_o
);
  logic           w_guard;
  logic           w_sticky;
  logic           w_lsb;
  logic           w_inc;
  logic [MAN:0]   w_sum;

  assign w_guard  = mag_i[W-2-MAN];
  assign w_sticky = |mag_i[W-3-MAN:0];
  assign w_lsb    = mag_i[W-1-MAN];
  assign w_inc    = w_guard & (w_sticky | w_lsb);

  // Carry out of the mantissa wraps f to zero and bumps the exponent.
  assign w_sum = {1'b0, mag_i[W-2 -: MAN]} + {{MAN{1'b0}}, w_inc};
  assign f_o   = w_sum[MAN-1:0];
  assign e_o   = e_i + {{(EXP-1){1'b0}}, w_sum[MAN]};
endmodule
`endif

// File: rtl/fx2bf16_norm.sv
// Signed fixed-point log2 result to bfloat16, normalised one shift per cycle.
// Define FX2BF16_RNE_EN for round-to-nearest-even instead of truncation.
module fx2bf16_norm
  import flog_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [EXP-1:0]    int_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              s_res_o,
  output logic [EXP-1:0]    e_res_o,
  output logic [MAN-1:0]    f_res_o
);
  fx2bf_state_t       r_state;
  fx2bf_state_t       w_state_next;
  logic [W-1:0]       r_x;
  logic [W-1:0]       r_mag;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sign;
  logic               r_valid;
  logic               r_s;
  logic [EXP-1:0]     r_e;
  logic [MAN-1:0]     r_f;

  logic [EXP-1:0]     w_e_trunc;
  logic [EXP-1:0]     w_e_res;
  logic [MAN-1:0]     w_f_res;
  logic               w_mag_zero;

  assign w_mag_zero = (r_mag == '0);
  assign w_e_trunc  = EXP'(BIAS + EXP - 1) - {{(EXP-CNT_W){1'b0}}, r_cnt};

`ifdef FX2BF16_RNE_EN
  bf16_round_rne u_round (
    .mag_i (r_mag),
    .e_i   (w_e_trunc),
    .f_o   (w_f_res),
    .e_o   (w_e_res)
  );
`else
  assign w_f_res = r_mag[W-2 -: MAN];
  assign w_e_res = w_e_trunc;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (valid_i) w_state_next = ABS;
      ABS:  w_state_next = NORM;
      NORM: if (w_mag_zero || r_mag[W-1]) w_state_next = OUT;
      OUT:  if (ready_i) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x     <= '0;
      r_mag   <= '0;
      r_cnt   <= '0;
      r_sign  <= 1'b0;
      r_valid <= 1'b0;
      r_s     <= 1'b0;
      r_e     <= '0;
      r_f     <= '0;
    end else begin
      case (r_state)
        IDLE: if (valid_i) r_x <= {int_i, frac_i};
        ABS: begin
          // Two's-complement negate modulo 2^W: the most negative input maps to itself.
          r_sign <= r_x[W-1];
          r_mag  <= r_x[W-1] ? -r_x : r_x;
          r_cnt  <= '0;
        end
        NORM: begin
          if (w_mag_zero) begin
            r_s     <= 1'b0;
            r_e     <= '0;
            r_f     <= '0;
            r_valid <= 1'b1;
          end else if (r_mag[W-1]) begin
            r_s     <= r_sign;
            r_e     <= w_e_res;
            r_f     <= w_f_res;
            r_valid <= 1'b1;
          end else begin
            r_mag <= r_mag << 1;
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        OUT: if (ready_i) r_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign ready_o = (r_state == IDLE);
  assign valid_o = r_valid;
  assign s_res_o = r_s;
  assign e_res_o = r_e;
  assign f_res_o = r_f;
endmodule

// File: tb/tb_fx2bf16_norm.sv
// Directed plus randomised checks of fx2bf16_norm against an arithmetic reference.
// Expectations follow FX2BF16_RNE_EN when it is defined for the build.
module tb_fx2bf16_norm;
  import flog_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_i;
  logic              ready_o;
  logic [EXP-1:0]    int_i;
  logic [FRAC_W-1:0] frac_i;
  logic              valid_o;
  logic              ready_i;
  logic              s_res_o;
  logic [EXP-1:0]    e_res_o;
  logic [MAN-1:0]    f_res_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fx2bf16_norm dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .int_i   (int_i),
    .frac_i  (frac_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .s_res_o (s_res_o),
    .e_res_o (e_res_o),
    .f_res_o (f_res_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Value = iv + fv/128; bfloat16 of |value| built from its leading-one position.
  function automatic void model(input int iv, input int fv,
                                output logic [15:0] bf, output int lat);
    int v, mag, p, e, q, rem, half, sgn;
    v   = iv * (1 << FRAC_W) + fv;
    sgn = (v < 0) ? 1 : 0;
    mag = (v < 0) ? -v : v;
    if (mag == 0) begin
      bf  = 16'h0000;
      lat = 2;
      return;
    end
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    e   = BIAS + p - FRAC_W;
    q   = (mag << MAN) >> p;
    rem = (mag << MAN) - (q << p);
`ifdef FX2BF16_RNE_EN
    if (p > 0) begin
      half = 1 << (p - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
      if (q == (1 << (MAN + 1))) begin
        q = 1 << MAN;
        e++;
      end
    end
`else
    half = rem;
`endif
    bf  = {sgn[0], e[7:0], q[6:0]};
    lat = 2 + (W - 1 - p);
  endfunction

  task automatic run_conv(input int iv, input int fv, input int bp, input string tag);
    logic [15:0] exp_bf;
    logic [15:0] held;
    int exp_lat;
    int cyc;
    model(iv, fv, exp_bf, exp_lat);
    check({tag, ".ready_before"}, {31'b0, ready_o}, 32'd1);
    int_i   = iv[7:0];
    frac_i  = fv[6:0];
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    cyc = 0;
    while (!valid_o && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".latency"}, cyc, exp_lat);
    check({tag, ".result"}, {16'b0, s_res_o, e_res_o, f_res_o}, {16'b0, exp_bf});
    $display("conv %s int=%0d frac=0x%02h -> 0x%04h lat=%0d (exp 0x%04h lat=%0d)",
             tag, iv, fv, {s_res_o, e_res_o, f_res_o}, cyc, exp_bf, exp_lat);
    held = {s_res_o, e_res_o, f_res_o};
    for (int k = 0; k < bp; k++) begin
      valid_i = 1'($urandom);
      int_i   = 8'($urandom);
      frac_i  = 7'($urandom);
      @(negedge clk);
      check({tag, ".bp_hold"}, {16'b0, s_res_o, e_res_o, f_res_o}, {16'b0, held});
      check({tag, ".bp_ready_o"}, {31'b0, ready_o}, 32'd0);
      check({tag, ".bp_valid_o"}, {31'b0, valid_o}, 32'd1);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    check({tag, ".drain_valid_o"}, {31'b0, valid_o}, 32'd0);
    check({tag, ".drain_ready_o"}, {31'b0, ready_o}, 32'd1);
  endtask

  initial begin
    rst     = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    int_i   = '0;
    frac_i  = '0;
    repeat (3) @(negedge clk);
    check("reset.valid_o", {31'b0, valid_o}, 32'd0);
    check("reset.outs", {16'b0, s_res_o, e_res_o, f_res_o}, 32'd0);
    check("reset.ready_o", {31'b0, ready_o}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    run_conv(3, 0, 0, "pos3");
    run_conv(-1, 'h40, 0, "neg_half");
    run_conv(0, 0, 0, "zero");
    run_conv(-128, 0, 0, "min_int");
    run_conv(3, 'h7F, 0, "round_case");
    run_conv(0, 1, 0, "max_shift");
    run_conv(-1, 'h7F, 0, "neg_tiny");
    run_conv(127, 'h7F, 0, "max_pos");
    run_conv(3, 0, 5, "backpressure");
    // valid_i pulses during OUT must not have started a new conversion.
    @(negedge clk);
    check("bp.no_ghost_ready", {31'b0, ready_o}, 32'd1);
    check("bp.no_ghost_valid", {31'b0, valid_o}, 32'd0);

    for (int n = 0; n < 24; n++)
      run_conv(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 127)),
               int'($urandom_range(0, 2)), $sformatf("rand%0d", n));

    // Reset while shifting in NORM discards the word and clears held outputs.
    run_conv(-2, 'h11, 0, "pre_reset");
    int_i   = 8'd0;
    frac_i  = 7'd1;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst.valid_o", {31'b0, valid_o}, 32'd0);
    check("midrst.outs", {16'b0, s_res_o, e_res_o, f_res_o}, 32'd0);
    check("midrst.ready_o", {31'b0, ready_o}, 32'd1);
    run_conv(-1, 'h40, 0, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
